// File: rtl/serial_full_adder_unit.sv
// serial_full_adder_unit
//   Bit-serial unsigned adder. It uses one full-adder cell and one carry flop,
//   and processes one bit per clock, LSB first. The operands and carry_in are
//   captured on an accepted start. The result is presented with a one-cycle
//   done pulse and held until the next result.
//
//   Optional build macro: SERIAL_FULL_ADDER_SUBTRACT_EN
//     When defined, the 'sub' input is present. With sub=1 the unit computes
//     a - b - borrow_in, where carry_in acts as borrow_in. In that mode
//     carry_out=1 means no borrow occurred.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   start      request, sampled only in IDLE
//   sub        (optional) subtract select, captured with the operands
//   a, b       operands, captured when start is accepted
//   carry_in   initial carry (borrow_in when subtracting)
//   busy       high in SHIFT and DONE
//   done       one-cycle pulse, result valid
//   sum        registered result
//   carry_out  registered final carry
//
// state  | meaning
// IDLE   | waiting for start
// SHIFT  | one bit processed per clock, WIDTH clocks in total
// DONE   | result valid, done pulse, then IDLE
module serial_full_adder_unit #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SERIAL_FULL_ADDER_SUBTRACT_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic [CNT_W-1:0] r_cnt;
  logic             r_c;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic [WIDTH-1:0] w_b_in;
  logic             w_c_in;
  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_sum_next;
  logic             w_last;

  // Subtraction is a + ~b + ~borrow_in. Inverting at capture time leaves the
  // datapath identical for add and subtract.
`ifdef SERIAL_FULL_ADDER_SUBTRACT_EN
  assign w_b_in = sub ? ~b : b;
  assign w_c_in = sub ? ~carry_in : carry_in;
`else
  assign w_b_in = b;
  assign w_c_in = carry_in;
`endif

  assign w_s        = r_a_sh[0] ^ r_b_sh[0] ^ r_c;
  assign w_c        = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_c) | (r_b_sh[0] & r_c);
  assign w_sum_next = {w_s, r_sum_sh[WIDTH-1:1]};
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_cnt    <= '0;
      r_c      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= w_b_in;
            r_c     <= w_c_in;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_c      <= w_c;
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_sum_sh <= w_sum_next;
          r_cnt    <= r_cnt + CNT_W'(1);
          // The final bit goes straight into the result registers. This way
          // sum/carry_out are stable for the whole DONE cycle.
          if (w_last) begin
            r_sum   <= w_sum_next;
            r_cout  <= w_c;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign sum       = r_sum;
  assign carry_out = r_cout;

endmodule

// File: tb/tb_serial_full_adder_unit.sv
module tb_serial_full_adder_unit;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] prev_sum  = '0;
  logic         prev_cout = 1'b0;

  serial_full_adder_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
`ifdef SERIAL_FULL_ADDER_SUBTRACT_EN
    .sub       (sub),
`endif
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: the result is whole-word arithmetic on the captured values.
  function automatic logic [W:0] ref_result(input logic [W-1:0] av, input logic [W-1:0] bv,
                                            input logic cin, input logic subv);
    logic [W:0] t;
    if (subv)
      t = {1'b0, av} + {1'b0, ~bv} + (W+1)'(!cin);
    else
      t = {1'b0, av} + {1'b0, bv} + (W+1)'(cin);
    return t;
  endfunction

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cin,
                        input logic subv, input int inject_at, input string tag);
    logic [W:0] e;
    int lat;
    bit seen;
    bit held;
    int extra_done;
    logic eff_sub;
`ifdef SERIAL_FULL_ADDER_SUBTRACT_EN
    eff_sub = subv;
`else
    eff_sub = 1'b0;
`endif
    e = ref_result(av, bv, cin, eff_sub);
    @(negedge clk);
    a = av; b = bv; carry_in = cin; sub = subv; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    carry_in = 1'($urandom);
    sub = 1'($urandom);
    lat = 0; seen = 0; held = 1; extra_done = 0;
    while (lat < W + 6 && !seen) begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk({tag, "_busy"}, 32'(busy), 32'd1);
      if (inject_at != 0 && lat == inject_at) begin
        start = 1'b1; a = 8'h11; b = 8'h22;
      end
      if (inject_at != 0 && lat == inject_at + 1) start = 1'b0;
      if (done) seen = 1;
      else if (sum !== prev_sum || carry_out !== prev_cout) held = 0;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(W + 1));
    chk({tag, "_held"}, 32'(held), 32'd1);
    chk({tag, "_sum"}, 32'(sum), 32'(e[W-1:0]));
    chk({tag, "_cout"}, 32'(carry_out), 32'(e[W]));
    @(negedge clk);
    if (done) extra_done++;
    chk({tag, "_done_pulse"}, 32'(extra_done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_sum_hold"}, 32'(sum), 32'(e[W-1:0]));
    prev_sum  = e[W-1:0];
    prev_cout = e[W];
  endtask

  initial begin
    int nd;
    bit bad;
    reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; carry_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(carry_out), 32'd0);
    bad = 0;
    a = 8'hAA; b = 8'h55;
    repeat (4) begin
      @(negedge clk);
      if (busy || done || sum != 0 || carry_out) bad = 1;
    end
    chk("rst_quiet", 32'(bad), 32'd0);

    run_op(8'h3C, 8'h41, 1'b0, 1'b0, 0, "add");
    run_op(8'hFF, 8'h01, 1'b1, 1'b0, 0, "ovf");
    run_op(8'h80, 8'h80, 1'b0, 1'b0, 3, "ign");

    // Abort mid-operation.
    @(negedge clk);
    a = 8'h12; b = 8'h34; carry_in = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(carry_out), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    nd = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    prev_sum = '0; prev_cout = 1'b0;
    run_op(8'h05, 8'h0A, 1'b0, 1'b0, 0, "fresh");

`ifdef SERIAL_FULL_ADDER_SUBTRACT_EN
    run_op(8'h10, 8'h01, 1'b0, 1'b1, 0, "sub1");
    run_op(8'h01, 8'h02, 1'b0, 1'b1, 0, "sub2");
`endif

    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 0, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_full_adder_unit.md
Name: serial_full_adder_unit

Overview:
Bit-serial N-bit adder, the arithmetic counterpart of the team's gate-level full subtracter. Loads two operands and a carry-in on a start pulse. Processes one bit per clock, LSB first, through a single full-adder cell and a carry flop. Presents the sum and carry-out with a one-cycle done pulse. Used as a small-area arithmetic unit in the same example library.

Parameters:
- WIDTH, 8, operand and sum width in bits (>=2).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A, captured when start is accepted.
- b  input  WIDTH  operand B, captured when start is accepted.
- carry_in  input  1  initial carry, captured with the operands.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  registered result, held until the next result.
- carry_out  output  1  registered final carry, held with sum.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port reset.
- While reset is high, all outputs and state are 0: state=IDLE, busy=0, done=0, sum=0, carry_out=0, internal shift registers=0, counter=0, carry flop=0.
- FSM states:
  - IDLE. start=1 at an edge: capture a, b into shift registers and carry_in into the carry flop, clear the counter, go to SHIFT.
  - SHIFT. At each edge:
    - s = a_sh[0] ^ b_sh[0] ^ c.
    - c <= majority(a_sh[0], b_sh[0], c).
    - a_sh and b_sh shift right by one.
    - s enters the MSB of the sum shift register.
    - The counter increments.
    - When the counter reaches WIDTH-1 at this edge, go to DONE. The WIDTH-th bit is processed at this edge and the result registers load the final values: sum <= completed shift register, carry_out <= final carry.
  - DONE. done=1 for exactly one cycle, then IDLE.
- Latency: start sampled at edge k; busy=1 from edge k; done=1 in the cycle after edge k+WIDTH. Result valid while done=1 and held afterwards. Next accepted start at the earliest edge k+WIDTH+2.
- start in SHIFT or DONE is ignored; no queueing and no effect on the operation in progress.
- sum and carry_out do not change during SHIFT. They change only on the SHIFT->DONE transition or on reset.
- Arithmetic: {carry_out, sum} = a + b + carry_in, modulo 2^(WIDTH+1), unsigned.
- Reset asserted mid-operation aborts immediately to the reset values above; there is no done pulse for the aborted operation.
- Operands change after capture: no effect.

Optional Feature:
- Macro: SERIAL_FULL_ADDER_SUBTRACT_EN.
- When defined:
  - Extra input port sub (1 bit), captured with the operands.
  - If sub=1: b is bit-inverted on capture and the carry flop is loaded with ~carry_in. The carry_in port then acts as borrow-in.
  - Result: sum = a - b - borrow_in mod 2^WIDTH; carry_out = 1 means no borrow, so borrow = ~carry_out.
  - If sub=0: identical to the add behaviour.
- When undefined: no sub port; add only.
- Latency and the handshake are identical in both builds.

Test Plan:
- Reset: assert reset for 3 cycles, then release -> busy=0, done=0, sum=0x00, carry_out=0; nothing changes until start.
- Add (WIDTH=8): a=0x3C, b=0x41, carry_in=0, start pulse -> done exactly 9 cycles after the start edge; sum=0x7D, carry_out=0.
- Overflow with carry_in: a=0xFF, b=0x01, carry_in=1 -> sum=0x01, carry_out=1; the previous result is held during SHIFT.
- Start ignored while busy: pulse start with a=0x11, b=0x22 three cycles into an operation on a=0x80, b=0x80 -> sum=0x00, carry_out=1; only one done pulse.
- Abort: assert reset at cycle 4 of an operation -> outputs go to 0 asynchronously and no done pulse. A fresh add of a=0x05, b=0x0A then gives sum=0x0F.
- With SERIAL_FULL_ADDER_SUBTRACT_EN: sub=1, a=0x10, b=0x01, carry_in=0 -> sum=0x0F, carry_out=1. Then a=0x01, b=0x02 -> sum=0xFF, carry_out=0 (borrow).
